// File: rtl/sniff_pkg.sv
// Shared definitions for the sniffer datapath: byte width, transmit FSM states
// and the ASCII constants used by both the source and the Comparison front end.
package sniff_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] CH_SPACE = 8'h20;
  localparam logic [DATA_W-1:0] CH_0     = 8'h30;
  localparam logic [DATA_W-1:0] CH_9     = 8'h39;

  function automatic logic is_digit(input logic [DATA_W-1:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/sniff_byte_fifo.sv
// Circular byte buffer with extra-bit pointers; full/empty come straight from
// the registered pointers so they never depend on the same-cycle push/pop.
module sniff_byte_fifo
  import sniff_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_overflow;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_pop && !o_empty;
  assign o_overflow = r_overflow;
  assign o_head     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      if (i_push && o_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sniff_byte_source.sv
// Paced byte transmitter: replays buffered bytes one per strobe toward the
// Comparison front end, with optional idle gap cycles after every byte.
module sniff_byte_source
  import sniff_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int GAP   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  input  logic             start,
  input  logic             stop,
  output logic [7:0]       data_out,
  output logic             enable,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t            r_state;
  state_t            w_state_next;
  logic [GW-1:0]     r_gap_cnt;
  logic [GW-1:0]     w_gap_cnt_next;
  logic [7:0]        r_data;
  logic [7:0]        w_data_next;
  logic              r_enable;
  logic              w_enable_next;
  logic [CNT_W-1:0]  r_sent_cnt;
  logic [CNT_W-1:0]  w_sent_cnt_next;
  logic              w_pop;
  logic [7:0]        w_head;

  sniff_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (wr_en),
    .i_data     (wr_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (full),
    .o_empty    (empty),
    .o_overflow (overflow)
  );

  assign data_out = r_data;
  assign enable   = r_enable;
  assign sent_cnt = r_sent_cnt;
  assign busy     = (r_state != IDLE);

  always_comb begin
    w_state_next    = r_state;
    w_gap_cnt_next  = r_gap_cnt;
    w_data_next     = r_data;
    w_enable_next   = 1'b0;
    w_sent_cnt_next = r_sent_cnt;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (!stop && start) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (stop) begin
          w_state_next = IDLE;
        end else if (!empty) begin
          w_pop           = 1'b1;
          w_data_next     = w_head;
          w_enable_next   = 1'b1;
          w_sent_cnt_next = r_sent_cnt + CNT_W'(1);
          if (GAP > 0) begin
            w_state_next = sniff_pkg::GAP;
          end
        end
      end
      sniff_pkg::GAP: begin
        // The counter is cleared on every exit so each gap starts from zero.
        if (stop) begin
          w_state_next   = IDLE;
          w_gap_cnt_next = '0;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_state_next   = SEND;
          w_gap_cnt_next = '0;
        end else begin
          w_gap_cnt_next = r_gap_cnt + GW'(1);
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_gap_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gap_cnt  <= '0;
      r_data     <= '0;
      r_enable   <= 1'b0;
      r_sent_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_data     <= w_data_next;
      r_enable   <= w_enable_next;
      r_sent_cnt <= w_sent_cnt_next;
    end
  end

endmodule

// File: tb/tb_sniff_byte_source.sv
// Bench for sniff_byte_source: three configurations driven by shared inputs and
// checked every cycle against a queue-based transmitter model.
module tb_sniff_byte_source;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic start = 1'b0;
  logic stop = 1'b0;

  logic        full_v [N];
  logic        empty_v [N];
  logic        ovf_v [N];
  logic        enable_v [N];
  logic        busy_v [N];
  logic [7:0]  dout_v [N];
  logic [15:0] cnt_v [N];

  int checks = 0;
  int errors = 0;

  logic [7:0] pp_bytes [9] = '{8'h70, 8'h70, 8'h32, 8'h70, 8'h20, 8'h31, 8'h68, 8'h33, 8'h63};

  // Model state: one transmitter per instance.
  logic [7:0]  m_q [N][$];
  bit          m_run [N];
  int          m_cool [N];
  bit          m_en [N];
  logic [7:0]  m_last [N];
  logic [15:0] m_cnt [N];
  bit          m_ovf [N];

  always #5 clk = ~clk;

  sniff_byte_source #(.DEPTH(64), .GAP(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_v[0]), .empty(empty_v[0]), .overflow(ovf_v[0]),
    .start(start), .stop(stop), .data_out(dout_v[0]), .enable(enable_v[0]),
    .busy(busy_v[0]), .sent_cnt(cnt_v[0])
  );

  sniff_byte_source #(.DEPTH(16), .GAP(2), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_v[1]), .empty(empty_v[1]), .overflow(ovf_v[1]),
    .start(start), .stop(stop), .data_out(dout_v[1]), .enable(enable_v[1]),
    .busy(busy_v[1]), .sent_cnt(cnt_v[1])
  );

  sniff_byte_source #(.DEPTH(4), .GAP(0), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_v[2]), .empty(empty_v[2]), .overflow(ovf_v[2]),
    .start(start), .stop(stop), .data_out(dout_v[2]), .enable(enable_v[2]),
    .busy(busy_v[2]), .sent_cnt(cnt_v[2])
  );

  function automatic int gap_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 64 : ((i == 1) ? 16 : 4);
  endfunction

  function automatic logic [28:0] dut_vec(input int i);
    return {enable_v[i], busy_v[i], full_v[i], empty_v[i], ovf_v[i], dout_v[i], cnt_v[i]};
  endfunction

  function automatic logic [28:0] exp_vec(input int i);
    logic f, e;
    f = (m_q[i].size() == depth_of(i));
    e = (m_q[i].size() == 0);
    return {logic'(m_en[i]), logic'(m_run[i]), f, e, logic'(m_ovf[i]), m_last[i], m_cnt[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_q[i].delete();
      m_run[i]  = 0;
      m_cool[i] = 0;
      m_en[i]   = 0;
      m_last[i] = 8'h00;
      m_cnt[i]  = 16'h0;
      m_ovf[i]  = 0;
    end
  endtask

  // One clock edge: a running transmitter may emit only when its cooldown has
  // expired; writes land after the pop decision so they are visible next edge.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int sz;
      sz = m_q[i].size();
      m_en[i] = 0;
      if (!m_run[i]) begin
        if (!stop && start) m_run[i] = 1;
      end else if (m_cool[i] > 0) begin
        if (stop) begin
          m_run[i]  = 0;
          m_cool[i] = 0;
        end else begin
          m_cool[i] = m_cool[i] - 1;
        end
      end else if (stop) begin
        m_run[i] = 0;
      end else if (sz > 0) begin
        m_last[i] = m_q[i].pop_front();
        m_en[i]   = 1;
        m_cnt[i]  = m_cnt[i] + 16'd1;
        m_cool[i] = gap_of(i);
        if (i == 0) $display("tx: data_out=%02h sent_cnt=%0d", m_last[i], m_cnt[i]);
      end
      if (wr_en) begin
        if (sz == depth_of(i)) m_ovf[i] = 1;
        else m_q[i].push_back(wr_data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_str(input string s);
    for (int k = 0; k < s.len(); k++) begin
      wr_data = s[k];
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_vec(i) !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000}) begin
        errors++;
        $display("FAIL reset dut%0d: got %h required %h", i, dut_vec(i),
                 {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000});
      end
    end
    do_reset();
  endtask

  task automatic test_stream();
    logic [7:0] g0[$], g1[$];
    int c0[$], c1[$];
    do_reset();
    load_str("pp2p 1h3c");
    pulse_start();
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL stream dut%0d cyc %0d: got %h required %h", i, c, dut_vec(i), exp_vec(i));
        end
      end
      if (enable_v[0]) begin g0.push_back(dout_v[0]); c0.push_back(c); end
      if (enable_v[1]) begin g1.push_back(dout_v[1]); c1.push_back(c); end
    end
    checks++;
    if (g0.size() != 9 || g1.size() != 9) begin
      errors++;
      $display("FAIL stream_count: got %0d/%0d required 9/9", g0.size(), g1.size());
    end
    for (int k = 0; k < 9 && k < g0.size() && k < g1.size(); k++) begin
      checks++;
      if (g0[k] !== pp_bytes[k] || c0[k] != k || g1[k] !== pp_bytes[k] || c1[k] != 3 * k) begin
        errors++;
        $display("FAIL stream_byte %0d: got %02h@%0d / %02h@%0d required %02h@%0d / %02h@%0d",
                 k, g0[k], c0[k], g1[k], c1[k], pp_bytes[k], k, pp_bytes[k], 3 * k);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt_v[i] !== 16'd9 || empty_v[i] !== 1'b1 || busy_v[i] !== 1'b1 || dout_v[i] !== 8'h63) begin
        errors++;
        $display("FAIL stream_end dut%0d: got cnt=%0d empty=%b busy=%b data=%02h required 9 1 1 63",
                 i, cnt_v[i], empty_v[i], busy_v[i], dout_v[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] g[$];
    do_reset();
    for (int b = 8'h41; b <= 8'h44; b++) begin
      wr_data = 8'(b);
      wr_en = 1'b1;
      tick();
    end
    checks++;
    if (full_v[2] !== 1'b1 || ovf_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: got full=%b ovf=%b required 1 0", full_v[2], ovf_v[2]);
    end
    wr_data = 8'h45;
    tick();
    wr_en = 1'b0;
    checks++;
    if (full_v[2] !== 1'b1 || ovf_v[2] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got full=%b ovf=%b required 1 1", full_v[2], ovf_v[2]);
    end
    pulse_start();
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL ovf_run dut%0d cyc %0d: got %h required %h", i, c, dut_vec(i), exp_vec(i));
        end
      end
      if (enable_v[2]) g.push_back(dout_v[2]);
    end
    checks++;
    if (g.size() != 4) begin
      errors++;
      $display("FAIL ovf_count: got %0d required 4", g.size());
    end
    for (int k = 0; k < g.size() && k < 4; k++) begin
      checks++;
      if (g[k] !== 8'(8'h41 + k)) begin
        errors++;
        $display("FAIL ovf_byte %0d: got %02h required %02h", k, g[k], 8'(8'h41 + k));
      end
    end
  endtask

  task automatic test_stop_resume();
    logic [7:0] g[$];
    logic [7:0] tail [6];
    int n, c;
    tail = '{8'h70, 8'h20, 8'h31, 8'h68, 8'h33, 8'h63};
    do_reset();
    load_str("pp2p 1h3c");
    pulse_start();
    n = 0;
    c = 0;
    while (n < 3 && c < 30) begin
      tick();
      if (enable_v[0]) n++;
      c++;
    end
    checks++;
    if (n < 3) begin
      errors++;
      $display("FAIL stop_wait: got %0d strobes required 3 within 30 cycles", n);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL stop_hold dut%0d cyc %0d: got %h required %h", i, k, dut_vec(i), exp_vec(i));
        end
      end
    end
    checks++;
    if (cnt_v[0] !== 16'd3 || busy_v[0] !== 1'b0 || enable_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL stop_state: got cnt=%0d busy=%b en=%b required 3 0 0", cnt_v[0], busy_v[0], enable_v[0]);
    end
    pulse_start();
    for (int k = 0; k < 15; k++) begin
      tick();
      if (enable_v[0]) g.push_back(dout_v[0]);
    end
    checks++;
    if (g.size() != 6 || cnt_v[0] !== 16'd9) begin
      errors++;
      $display("FAIL resume_count: got %0d bytes cnt=%0d required 6 bytes cnt=9", g.size(), cnt_v[0]);
    end
    for (int k = 0; k < g.size() && k < 6; k++) begin
      checks++;
      if (g[k] !== tail[k]) begin
        errors++;
        $display("FAIL resume_byte %0d: got %02h required %02h", k, g[k], tail[k]);
      end
    end
  endtask

  task automatic test_visibility();
    do_reset();
    pulse_start();
    for (int k = 0; k < 3; k++) tick();
    wr_data = 8'h41;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++;
    if (enable_v[0] !== 1'b0 || empty_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL vis_edge_n: got en=%b empty=%b required 0 0", enable_v[0], empty_v[0]);
    end
    tick();
    checks++;
    if (enable_v[0] !== 1'b1 || dout_v[0] !== 8'h41 || cnt_v[0] !== 16'd1) begin
      errors++;
      $display("FAIL vis_edge_n1: got en=%b data=%02h cnt=%0d required 1 41 1", enable_v[0], dout_v[0], cnt_v[0]);
    end
    tick();
    checks++;
    if (enable_v[0] !== 1'b0 || dout_v[0] !== 8'h41) begin
      errors++;
      $display("FAIL vis_hold: got en=%b data=%02h required 0 41", enable_v[0], dout_v[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      wr_data = 8'($urandom_range(8'h21, 8'h7e));
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    pulse_start();
    tick();
    tick();
    checks++;
    if (enable_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || m_q[0].size() != 5) begin
      errors++;
      $display("FAIL arst_pre: got en=%b busy=%b queued=%0d required 1 1 5", enable_v[0], busy_v[0], m_q[0].size());
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (enable_v[0] !== 1'b0 || empty_v[0] !== 1'b1 || cnt_v[0] !== 16'd0 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL arst_now: got en=%b empty=%b cnt=%0d busy=%b required 0 1 0 0",
               enable_v[0], empty_v[0], cnt_v[0], busy_v[0]);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 24) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dut_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d: got %h required %h", i, c, dut_vec(i), exp_vec(i));
        end
      end
    end
    wr_en = 1'b0;
    start = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_overflow();
    test_stop_resume();
    test_visibility();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
